// File: rtl/hkspi_slave_sync.sv
// hkspi_slave_sync: housekeeping SPI slave (mode 0, MSB first) sampled in the
// system clock domain. Decodes stream and n-byte read / write / read-write
// commands and drives a byte-wide register bus with one-clock strobes.
// Optional flash pass-through is compiled in when HKSPI_PASSTHRU_EN is defined;
// without it command 0xC4 is ignored and the pt_* outputs sit at idle levels.
//
// Handshake: reg_we and reg_re are single-clock strobes that never coincide.
// reg_we carries reg_addr/reg_wdata in the same clock. After reg_re the
// register file presents reg_rdata on the following clock, where it is
// captured into the SDO shift register.
module hkspi_slave_sync #(
  parameter int ADDR_WIDTH  = 8,
  parameter int NUM_REGS    = 19,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  spi_sck,
  input  logic                  spi_csb,
  input  logic                  spi_sdi,
  output logic                  spi_sdo,
  output logic                  spi_sdo_oe,
  output logic [ADDR_WIDTH-1:0] reg_addr,
  output logic [7:0]            reg_wdata,
  output logic                  reg_we,
  output logic                  reg_re,
  input  logic [7:0]            reg_rdata,
  output logic                  busy,
  output logic                  pt_active,
  output logic                  pt_sck,
  output logic                  pt_csb,
  output logic                  pt_sdo,
  input  logic                  pt_sdi
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CMD      = 3'd1,
    ST_ADDR     = 3'd2,
    ST_DATA     = 3'd3,
    ST_PASSTHRU = 3'd4,
    ST_IGNORE   = 3'd5
  } state_t;

`ifdef HKSPI_PASSTHRU_EN
  localparam bit PT_EN = 1'b1;
`else
  localparam bit PT_EN = 1'b0;
`endif

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_REGS - 1);

  // Synchroniser chains and previous-value flops for edge detection
  logic [SYNC_STAGES-1:0] sck_sync_q;
  logic [SYNC_STAGES-1:0] csb_sync_q;
  logic [SYNC_STAGES-1:0] sdi_sync_q;
  logic                   sck_prev_q;
  logic                   csb_prev_q;

  // Protocol state
  state_t                 state_q;
  logic [2:0]             bit_cnt_q;
  logic [6:0]             shift_in_q;
  logic [7:0]             sdo_shift_q;
  logic [ADDR_WIDTH-1:0]  addr_q;
  logic [7:0]             wdata_q;
  logic                   we_q;
  logic                   re_q;
  logic                   wr_mode_q;
  logic                   rd_mode_q;
  logic [2:0]             nbyte_q;
  logic [2:0]             byte_cnt_q;
  logic                   step_q;      // byte boundary follow-up pending
  logic                   step_inc_q;  // follow-up advances the address
  logic                   load_q;      // reg_rdata is valid this clock
  logic                   busy_q;
  logic                   pt_active_q;

  // Derived combinational values
  logic                   sck_s;
  logic                   csb_s;
  logic                   sdi_s;
  logic                   sck_rise;
  logic                   sck_fall;
  logic                   csb_fall;
  logic                   csb_rise;
  logic                   in_frame;
  logic                   byte_done;
  logic [7:0]             rx_byte_d;
  logic [ADDR_WIDTH-1:0]  addr_next_d;
  logic                   cmd_valid_d;
  logic                   cmd_pt_d;
  logic                   last_byte_d;
  logic                   data_oe;

  assign sck_s = sck_sync_q[SYNC_STAGES-1];
  assign csb_s = csb_sync_q[SYNC_STAGES-1];
  assign sdi_s = sdi_sync_q[SYNC_STAGES-1];

  assign sck_rise = sck_s & ~sck_prev_q;
  assign sck_fall = ~sck_s & sck_prev_q;
  assign csb_fall = ~csb_s & csb_prev_q;
  assign csb_rise = csb_s & ~csb_prev_q;

  assign in_frame  = (state_q == ST_CMD) || (state_q == ST_ADDR) || (state_q == ST_DATA);
  assign byte_done = sck_rise && (bit_cnt_q == 3'd7);
  assign rx_byte_d = {shift_in_q, sdi_s};

  // Auto-increment wraps to 0 at the last implemented register; any address
  // loaded at or beyond it also wraps to 0 on its first increment.
  assign addr_next_d = (addr_q >= LAST_ADDR) ? '0 : addr_q + ADDR_WIDTH'(1);

  // Valid transfer commands are mmnnn000 with mm != 00 (0x00 is ignored).
  assign cmd_valid_d = (rx_byte_d[2:0] == 3'b000) && (rx_byte_d[7:6] != 2'b00);
  assign cmd_pt_d    = PT_EN && (rx_byte_d == 8'hC4);

  // Final byte of an n-byte transfer: no further address step or prefetch.
  assign last_byte_d = (nbyte_q != 3'd0) && (byte_cnt_q == 3'd1);

  assign data_oe = (state_q == ST_DATA) && rd_mode_q;

  // Pad synchronisers; CSB idles high so no false fall is seen after reset
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sck_sync_q <= '0;
      csb_sync_q <= '1;
      sdi_sync_q <= '0;
      sck_prev_q <= 1'b0;
      csb_prev_q <= 1'b1;
    end else begin
      sck_sync_q <= {sck_sync_q[SYNC_STAGES-2:0], spi_sck};
      csb_sync_q <= {csb_sync_q[SYNC_STAGES-2:0], spi_csb};
      sdi_sync_q <= {sdi_sync_q[SYNC_STAGES-2:0], spi_sdi};
      sck_prev_q <= sck_s;
      csb_prev_q <= csb_s;
    end
  end

  // Protocol FSM with registered strobes, address and SDO shift register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= 3'd0;
      shift_in_q  <= 7'd0;
      sdo_shift_q <= 8'd0;
      addr_q      <= '0;
      wdata_q     <= 8'd0;
      we_q        <= 1'b0;
      re_q        <= 1'b0;
      wr_mode_q   <= 1'b0;
      rd_mode_q   <= 1'b0;
      nbyte_q     <= 3'd0;
      byte_cnt_q  <= 3'd0;
      step_q      <= 1'b0;
      step_inc_q  <= 1'b0;
      load_q      <= 1'b0;
      busy_q      <= 1'b0;
      pt_active_q <= 1'b0;
    end else begin
      we_q   <= 1'b0;
      re_q   <= 1'b0;
      step_q <= 1'b0;
      load_q <= 1'b0;
      busy_q <= ~csb_s;

      // Boundary follow-up: advance address, then fetch the next read byte
      if (step_q) begin
        if (step_inc_q) addr_q <= addr_next_d;
        if (rd_mode_q) re_q <= 1'b1;
      end
      if (re_q) load_q <= 1'b1;

      // The fall right after a byte boundary (bit count 0) must not shift,
      // otherwise the freshly loaded MSB would be lost before it is sampled.
      if (load_q) begin
        sdo_shift_q <= reg_rdata;
      end else if (sck_fall && (state_q == ST_DATA) && (bit_cnt_q != 3'd0)) begin
        sdo_shift_q <= {sdo_shift_q[6:0], 1'b0};
      end

      if (sck_rise && in_frame) begin
        shift_in_q <= rx_byte_d[6:0];
        bit_cnt_q  <= bit_cnt_q + 3'd1;
      end

      if (csb_rise) begin
        // End of frame from any state; a partial byte is simply dropped
        state_q     <= ST_IDLE;
        bit_cnt_q   <= 3'd0;
        step_q      <= 1'b0;
        re_q        <= 1'b0;
        load_q      <= 1'b0;
        sdo_shift_q <= 8'd0;
        pt_active_q <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (csb_fall) begin
              state_q     <= ST_CMD;
              bit_cnt_q   <= 3'd0;
              addr_q      <= '0;
              sdo_shift_q <= 8'd0;
            end
          end
          ST_CMD: begin
            if (byte_done) begin
              if (cmd_pt_d) begin
                state_q     <= ST_PASSTHRU;
                pt_active_q <= 1'b1;
              end else if (cmd_valid_d) begin
                state_q    <= ST_ADDR;
                wr_mode_q  <= rx_byte_d[7];
                rd_mode_q  <= rx_byte_d[6];
                nbyte_q    <= rx_byte_d[5:3];
                byte_cnt_q <= rx_byte_d[5:3];
              end else begin
                state_q <= ST_IGNORE;
              end
            end
          end
          ST_ADDR: begin
            if (byte_done) begin
              // First read uses the address as received, no increment
              addr_q     <= ADDR_WIDTH'(rx_byte_d);
              state_q    <= ST_DATA;
              step_q     <= rd_mode_q;
              step_inc_q <= 1'b0;
            end
          end
          ST_DATA: begin
            if (byte_done) begin
              if (wr_mode_q) begin
                we_q    <= 1'b1;
                wdata_q <= rx_byte_d;
              end
              if (nbyte_q != 3'd0) byte_cnt_q <= byte_cnt_q - 3'd1;
              if (last_byte_d) begin
                state_q <= ST_IGNORE;
              end else begin
                step_q     <= 1'b1;
                step_inc_q <= 1'b1;
              end
            end
          end
          ST_PASSTHRU: begin
            // Held until CSB rises; pads are routed combinationally
          end
          ST_IGNORE: begin
            // Held until CSB rises; no strobes, output disabled
          end
          default: begin
            state_q <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign reg_addr  = addr_q;
  assign reg_wdata = wdata_q;
  assign reg_we    = we_q;
  assign reg_re    = re_q;
  assign busy      = busy_q;
  assign pt_active = pt_active_q;

`ifdef HKSPI_PASSTHRU_EN
  // Raw pad routing to the flash while pass-through is active
  assign pt_sck     = pt_active_q & spi_sck;
  assign pt_csb     = pt_active_q ? spi_csb : 1'b1;
  assign pt_sdo     = pt_active_q & spi_sdi;
  assign spi_sdo    = pt_active_q ? pt_sdi : (data_oe & sdo_shift_q[7]);
  assign spi_sdo_oe = pt_active_q | data_oe;
`else
  logic unused_pt_sdi;
  assign unused_pt_sdi = pt_sdi;
  assign pt_sck     = 1'b0;
  assign pt_csb     = 1'b1;
  assign pt_sdo     = 1'b0;
  assign spi_sdo    = data_oe & sdo_shift_q[7];
  assign spi_sdo_oe = data_oe;
`endif

endmodule

// File: tb/tb_hkspi_slave_sync.sv
// Bench for hkspi_slave_sync: SPI master driver, behavioural register-file
// environment, transaction-level reference model and write/read scoreboards.
module tb_hkspi_slave_sync;

  localparam int AW       = 8;
  localparam int NREGS    = 19;
  localparam int SYNC     = 2;
  localparam int HALF     = 6;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic          spi_sck = 1'b0;
  logic          spi_csb = 1'b1;
  logic          spi_sdi = 1'b0;
  logic          spi_sdo;
  logic          spi_sdo_oe;
  logic [AW-1:0] reg_addr;
  logic [7:0]    reg_wdata;
  logic          reg_we;
  logic          reg_re;
  logic [7:0]    reg_rdata = 8'd0;
  logic          busy;
  logic          pt_active;
  logic          pt_sck;
  logic          pt_csb;
  logic          pt_sdo;
  logic          pt_sdi = 1'b0;

  hkspi_slave_sync #(
    .ADDR_WIDTH (AW),
    .NUM_REGS   (NREGS),
    .SYNC_STAGES(SYNC)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .spi_sck   (spi_sck),
    .spi_csb   (spi_csb),
    .spi_sdi   (spi_sdi),
    .spi_sdo   (spi_sdo),
    .spi_sdo_oe(spi_sdo_oe),
    .reg_addr  (reg_addr),
    .reg_wdata (reg_wdata),
    .reg_we    (reg_we),
    .reg_re    (reg_re),
    .reg_rdata (reg_rdata),
    .busy      (busy),
    .pt_active (pt_active),
    .pt_sck    (pt_sck),
    .pt_csb    (pt_csb),
    .pt_sdo    (pt_sdo),
    .pt_sdi    (pt_sdi)
  );

  // ---------------- register-file environment ----------------
  logic [7:0] env_mem [256];
  logic [7:0] ref_mem [256];
  logic       load_mem = 1'b0;

  always @(posedge clock) begin
    if (load_mem) begin
      for (int i = 0; i < 256; i++) env_mem[i] <= ref_mem[i];
    end else begin
      if (reg_we) env_mem[reg_addr] <= reg_wdata;
      if (reg_re) reg_rdata <= env_mem[reg_addr];
    end
  end

  // ---------------- monitor / scoreboard ----------------
  logic [15:0] obs_we_q[$];
  logic [7:0]  obs_re_q[$];
  logic [15:0] exp_we_q[$];
  logic [7:0]  exp_re_q[$];
  int          both_cnt = 0;

  always @(negedge clock) begin
    if (reg_we) obs_we_q.push_back({reg_addr, reg_wdata});
    if (reg_re) obs_re_q.push_back(reg_addr);
    if (reg_we && reg_re) both_cnt++;
  end

  int total = 0;
  int bad   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- SPI master driver ----------------
  logic [7:0] tx     [32];
  logic [7:0] rx     [32];
  logic [7:0] exp_rx [32];

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic spi_xfer(input int len, input int last_bits, input bit keep_low);
    int nb;
    for (int b = 0; b < 32; b++) rx[b] = 8'd0;
    spi_csb = 1'b0;
    wait_clk(4);
    for (int b = 0; b < len; b++) begin
      nb = (b == len - 1) ? last_bits : 8;
      for (int i = 7; i >= 8 - nb; i--) begin
        spi_sdi = tx[b][i];
        wait_clk(HALF);
        rx[b][i] = spi_sdo;
        spi_sck = 1'b1;
        wait_clk(HALF);
        spi_sck = 1'b0;
      end
    end
    wait_clk(HALF);
    if (!keep_low) begin
      spi_csb = 1'b1;
      spi_sdi = 1'b0;
      wait_clk(8);
    end
  endtask

  // ---------------- reference model ----------------
  // Sequential transaction semantics: reads return the register value at the
  // time that byte is due, writes land in order, address wraps after NREGS-1.
  task automatic model_txn(input int len, input int last_bits);
    logic [7:0]    cmd;
    logic [AW-1:0] a;
    int            full, ndata, neff, n;
    bit            wr, rd;
    exp_we_q.delete();
    exp_re_q.delete();
    for (int b = 0; b < 32; b++) exp_rx[b] = 8'd0;
    full = (last_bits == 8) ? len : len - 1;
    cmd  = tx[0];
    if (full < 2) return;
    if (cmd[2:0] != 3'b000 || cmd[7:6] == 2'b00) return;
    wr    = cmd[7];
    rd    = cmd[6];
    n     = int'(cmd[5:3]);
    a     = tx[1];
    ndata = full - 2;
    neff  = (n != 0 && ndata > n) ? n : ndata;
    if (rd) exp_re_q.push_back(a);
    for (int j = 0; j < neff; j++) begin
      if (rd) exp_rx[2 + j] = ref_mem[a];
      if (wr) begin
        exp_we_q.push_back({a, tx[2 + j]});
        ref_mem[a] = tx[2 + j];
      end
      if (!(n != 0 && j == n - 1)) begin
        a = (int'(a) >= NREGS - 1) ? '0 : a + 8'd1;
        if (rd) exp_re_q.push_back(a);
      end
    end
  endtask

  task automatic compare_txn(input string name, input int full);
    check_val({name, ".we_n"}, obs_we_q.size(), exp_we_q.size());
    for (int i = 0; i < obs_we_q.size() && i < exp_we_q.size(); i++)
      check_val($sformatf("%s.we%0d", name, i), obs_we_q[i], exp_we_q[i]);
    check_val({name, ".re_n"}, obs_re_q.size(), exp_re_q.size());
    for (int i = 0; i < obs_re_q.size() && i < exp_re_q.size(); i++)
      check_val($sformatf("%s.re%0d", name, i), obs_re_q[i], exp_re_q[i]);
    for (int b = 0; b < full; b++)
      check_val($sformatf("%s.rx%0d", name, b), rx[b], exp_rx[b]);
    check_val({name, ".busy"}, busy, 0);
    check_val({name, ".oe"}, spi_sdo_oe, 0);
    obs_we_q.delete();
    obs_re_q.delete();
  endtask

  task automatic run_txn(input string name, input int len, input int last_bits);
    model_txn(len, last_bits);
    spi_xfer(len, last_bits, 1'b0);
    compare_txn(name, (last_bits == 8) ? len : len - 1);
  endtask

  task automatic check_reset_vals(input string name);
    check_val({name, ".addr"}, reg_addr, 0);
    check_val({name, ".wdata"}, reg_wdata, 0);
    check_val({name, ".we"}, reg_we, 0);
    check_val({name, ".re"}, reg_re, 0);
    check_val({name, ".busy"}, busy, 0);
    check_val({name, ".sdo"}, spi_sdo, 0);
    check_val({name, ".oe"}, spi_sdo_oe, 0);
    check_val({name, ".pt_act"}, pt_active, 0);
    check_val({name, ".pt_sck"}, pt_sck, 0);
    check_val({name, ".pt_csb"}, pt_csb, 1);
    check_val({name, ".pt_sdo"}, pt_sdo, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    #3_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int len, lb, mode, n;
    logic [7:0] cmd;

    for (int i = 0; i < 256; i++) ref_mem[i] = 8'($urandom_range(0, 255));
    ref_mem[0]  = 8'h00;
    ref_mem[1]  = 8'h04;
    ref_mem[2]  = 8'h56;
    ref_mem[3]  = 8'h10;
    ref_mem[18] = 8'h04;

    wait_clk(2);
    load_mem = 1'b1;
    wait_clk(1);
    load_mem = 1'b0;
    wait_clk(2);
    check_reset_vals("rst");
    reset = 1'b0;
    wait_clk(4);
    check_reset_vals("post_rst");

    // Stream read of register 3
    tx[0] = 8'h40; tx[1] = 8'h03; tx[2] = 8'h00;
    run_txn("rd3", 3, 8);

    // Stream read across the wrap point
    tx[0] = 8'h40; tx[1] = 8'h00;
    for (int j = 0; j < 20; j++) tx[2 + j] = 8'h00;
    run_txn("rdwrap", 22, 8);

    // Stream writes, then read back
    tx[0] = 8'h80; tx[1] = 8'h07; tx[2] = 8'h01;
    run_txn("wr7a", 3, 8);
    tx[2] = 8'h00;
    run_txn("wr7b", 3, 8);
    tx[0] = 8'h40; tx[1] = 8'h07; tx[2] = 8'h00;
    run_txn("rd7", 3, 8);

    // n-byte write, n = 3, fourth byte dropped
    tx[0] = 8'h98; tx[1] = 8'h10;
    tx[2] = 8'hAA; tx[3] = 8'hBB; tx[4] = 8'hCC; tx[5] = 8'hDD;
    run_txn("nwr3", 6, 8);

    // Abort inside a write byte, then read the untouched register
    tx[0] = 8'h80; tx[1] = 8'h05; tx[2] = 8'hFF;
    run_txn("abort", 3, 5);
    tx[0] = 8'h40; tx[1] = 8'h05; tx[2] = 8'h00;
    run_txn("rd5", 3, 8);

    // Reset in the middle of a write byte
    tx[0] = 8'h80; tx[1] = 8'h04; tx[2] = 8'hA5;
    spi_xfer(3, 4, 1'b1);
    reset = 1'b1;
    wait_clk(2);
    check_reset_vals("midrst");
    spi_csb = 1'b1;
    wait_clk(4);
    reset = 1'b0;
    wait_clk(6);
    check_val("midrst.we_n", obs_we_q.size(), 0);
    obs_we_q.delete();
    obs_re_q.delete();

    // Pass-through command
    tx[0] = 8'hC4;
    spi_xfer(1, 8, 1'b1);
    wait_clk(4);
`ifdef HKSPI_PASSTHRU_EN
    check_val("pt.active", pt_active, 1);
    check_val("pt.oe", spi_sdo_oe, 1);
    check_val("pt.csb_lo", pt_csb, 0);
    spi_sck = 1'b1; spi_sdi = 1'b1; pt_sdi = 1'b1;
    #1;
    check_val("pt.sck_hi", pt_sck, 1);
    check_val("pt.sdo_hi", pt_sdo, 1);
    check_val("pt.miso_hi", spi_sdo, 1);
    spi_sck = 1'b0; spi_sdi = 1'b0; pt_sdi = 1'b0;
    #1;
    check_val("pt.sck_lo", pt_sck, 0);
    check_val("pt.sdo_lo", pt_sdo, 0);
    check_val("pt.miso_lo", spi_sdo, 0);
    spi_csb = 1'b1;
    #1;
    check_val("pt.csb_hi", pt_csb, 1);
    wait_clk(6);
    check_val("pt.exit", pt_active, 0);
    check_val("pt.exit_oe", spi_sdo_oe, 0);
`else
    check_val("pt.active", pt_active, 0);
    check_val("pt.csb", pt_csb, 1);
    check_val("pt.oe", spi_sdo_oe, 0);
    spi_sck = 1'b1; spi_sdi = 1'b1; pt_sdi = 1'b1;
    #1;
    check_val("pt.sck", pt_sck, 0);
    check_val("pt.sdo", pt_sdo, 0);
    check_val("pt.miso", spi_sdo, 0);
    spi_sck = 1'b0; spi_sdi = 1'b0; pt_sdi = 1'b0;
    spi_csb = 1'b1;
    wait_clk(6);
    check_val("pt.idle_active", pt_active, 0);
`endif
    check_val("pt.we_n", obs_we_q.size(), 0);
    check_val("pt.re_n", obs_re_q.size(), 0);
    obs_we_q.delete();
    obs_re_q.delete();

    // Randomised transactions
    for (int t = 0; t < 20; t++) begin
      if ($urandom_range(0, 7) == 0) begin
        cmd = (t % 2 == 0) ? 8'h00 : (8'($urandom_range(0, 255)) | 8'h01);
      end else begin
        mode = $urandom_range(1, 3);
        n    = $urandom_range(0, 7);
        cmd  = {2'(mode), 3'(n), 3'b000};
      end
      tx[0] = cmd;
      tx[1] = 8'($urandom_range(0, NREGS + 3));
      len   = 2 + $urandom_range(0, 6);
      for (int j = 2; j < len; j++) tx[j] = 8'($urandom_range(0, 255));
      lb    = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 8;
      run_txn($sformatf("rnd%0d", t), len, lb);
    end

    check_val("no_we_re_overlap", both_cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
